// File: rtl/puf_auth_verifier.sv
`default_nettype none
// ============================================================================
// Module      : puf_auth_verifier
// Description : Challenge-issuing verifier for a 4-response arbiter PUF.
//               Issues an LFSR challenge sequence, waits a settle time per
//               challenge, samples the response, then enrolls it or counts
//               bit mismatches against the enrolled values.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_auth_verifier #(
  parameter int          N_CHAL  = 16,
  parameter int          SETTLE  = 4,
  parameter int          MAX_ERR = 3,
  parameter logic [31:0] SEED    = 32'hACE1_2345
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  output logic [31:0] chal,
  input  logic [3:0]  resp,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_cnt,
  output logic        enrolled
);

  localparam int IDX_W = (N_CHAL > 1) ? $clog2(N_CHAL) : 1;
  localparam int CNT_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        chal_q, chal_d;
  logic               mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [7:0]         err_q, err_d;
  logic               enrolled_q, enrolled_d;

  logic [3:0]         mem [N_CHAL];
  logic               mem_we;
  logic [3:0]         diff;
  logic [8:0]         err_sum;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] c);
    lfsr_next = {c[30:0], c[31] ^ c[21] ^ c[1] ^ c[0]};
  endfunction

  // Mismatch accumulation: 9-bit sum so the clamp to 255 sees the carry
  assign diff    = resp ^ mem[idx_q];
  assign err_sum = {1'b0, err_q} + 9'(popcount4(diff));

  // Next-state and next-output logic for the run sequencer
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    chal_d     = chal_q;
    mode_d     = mode_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    enrolled_d = enrolled_q;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          idx_d  = '0;
          cnt_d  = '0;
          err_d  = '0;
          pass_d = 1'b0;
          chal_d = SEED;
          if (mode && !enrolled_q) begin
            // Nothing to compare against: fail immediately
            state_d = S_FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_SETTLE;
            busy_d  = 1'b1;
            if (!mode) enrolled_d = 1'b0;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) state_d = S_SAMPLE;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      S_SAMPLE: begin
        if (!mode_q) mem_we = 1'b1;
        else         err_d  = err_sum[8] ? 8'hFF : err_sum[7:0];
        if (idx_q == IDX_W'(N_CHAL - 1)) begin
          // done/busy are registered, so they change together entering FINISH
          state_d = S_FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          if (!mode_q) begin
            pass_d     = 1'b1;
            enrolled_d = 1'b1;
            err_d      = '0;
          end else begin
            pass_d = (int'(err_d) <= MAX_ERR);
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          cnt_d   = '0;
          chal_d  = lfsr_next(chal_q);
          state_d = S_SETTLE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      chal_q     <= '0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      enrolled_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      chal_q     <= chal_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      enrolled_q <= enrolled_d;
    end
  end

  // Enrolled response storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= resp;
  end

  assign chal     = chal_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign enrolled = enrolled_q;

endmodule
`default_nettype wire
